// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: round-robin between
// core (port 0) and debug/DMA (port 1), with lockable ownership and 1-cycle read return.
module data_mem_arbiter #(
    parameter int MEMORY_WIDTH = 32,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic                    p0_lock,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [MEMORY_WIDTH-1:0] p0_wdata,
    output logic                    p0_gnt,
    output logic                    p0_rvalid,
    output logic [MEMORY_WIDTH-1:0] p0_rdata,
    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic                    p1_lock,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [MEMORY_WIDTH-1:0] p1_wdata,
    output logic                    p1_gnt,
    output logic                    p1_rvalid,
    output logic [MEMORY_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [MEMORY_WIDTH-1:0] mem_write_data,
    output logic                    mem_write_enable,
    input  logic [MEMORY_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;

    // Grant is a pure function of the current requests and the ownership state,
    // so the memory sees the access in the same cycle it is requested.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req && p1_req) begin
                    p0_gnt = last_grant;
                    p1_gnt = ~last_grant;
                end else begin
                    p0_gnt = p0_req;
                    p1_gnt = p1_req;
                end
            end
            OWN0:    p0_gnt = p0_req;
            OWN1:    p1_gnt = p1_req;
            default: ;
        endcase
    end

    always_comb begin
        mem_addr         = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        if (p0_gnt) begin
            mem_addr         = p0_addr;
            mem_write_data   = p0_wdata;
            mem_write_enable = p0_we;
        end else if (p1_gnt) begin
            mem_addr         = p1_addr;
            mem_write_data   = p1_wdata;
            mem_write_enable = p1_we;
        end
    end

    // Ownership only ends when the owner either releases lock on a granted
    // access or lets its request drop; an idle cycle always returns to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (p0_gnt) begin
                last_grant <= 1'b0;
                state      <= p0_lock ? OWN0 : IDLE;
            end else if (p1_gnt) begin
                last_grant <= 1'b1;
                state      <= p1_lock ? OWN1 : IDLE;
            end else begin
                state <= IDLE;
            end

            p0_rvalid <= p0_gnt && !p0_we;
            p1_rvalid <= p1_gnt && !p1_we;
            if (p0_gnt && !p0_we) p0_rdata <= mem_read_data;
            if (p1_gnt && !p1_we) p1_rdata <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: table of per-cycle request vectors
// with expected grants, plus a read-return scoreboard and hand-written reset cases.
module tb_data_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [AW-1:0] p0_addr, p1_addr, mem_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, mem_write_data, mem_read_data;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_write_enable;
    logic [DW-1:0] p0_rdata, p1_rdata;

    always #5 clk = ~clk;

    data_mem_arbiter #(.MEMORY_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    // Behavioural memory seen by the DUT, and an independent model of its contents.
    logic [DW-1:0] tbmem     [256];
    logic [DW-1:0] model_mem [256];
    assign mem_read_data = tbmem[mem_addr];

    typedef struct {
        logic          r0, w0, l0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1, l1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0, g1;
    } vec_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb[$];
    vec_t          vecs[$];
    logic [DW-1:0] exp_rd0, exp_rd1;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hC0DE_0000 + 32'(i * 3);
    endfunction

    function automatic vec_t mk(input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic g0, g1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    // One cycle: drive at negedge, then compare registered read return and
    // combinational grant/memory outputs, then record what this cycle should cause.
    task automatic apply(input vec_t v, input string tag);
        sb_t           e;
        logic          erv0, erv1, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        p0_req = v.r0; p0_we = v.w0; p0_lock = v.l0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req = v.r1; p1_we = v.w1; p1_lock = v.l1; p1_addr = v.a1; p1_wdata = v.d1;
        #1;
        erv0 = 1'b0;
        erv1 = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == 1'b0) begin erv0 = 1'b1; exp_rd0 = e.data; end
            else                begin erv1 = 1'b1; exp_rd1 = e.data; end
        end
        check({tag, " p0_rvalid"}, 32'(p0_rvalid), 32'(erv0));
        check({tag, " p1_rvalid"}, 32'(p1_rvalid), 32'(erv1));
        check({tag, " p0_rdata"}, p0_rdata, exp_rd0);
        check({tag, " p1_rdata"}, p1_rdata, exp_rd1);

        ea = '0; ed = '0; ewe = 1'b0;
        if (v.g0)      begin ea = v.a0; ed = v.d0; ewe = v.w0; end
        else if (v.g1) begin ea = v.a1; ed = v.d1; ewe = v.w1; end
        check({tag, " p0_gnt"}, 32'(p0_gnt), 32'(v.g0));
        check({tag, " p1_gnt"}, 32'(p1_gnt), 32'(v.g1));
        check({tag, " mem_write_enable"}, 32'(mem_write_enable), 32'(ewe));
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(ea));
        check({tag, " mem_write_data"}, mem_write_data, ed);

        if (v.g0 && !v.w0) sb.push_back('{1'b0, model_mem[v.a0]});
        if (v.g1 && !v.w1) sb.push_back('{1'b1, model_mem[v.a1]});
        if (v.g0 && v.w0) model_mem[v.a0] = v.d0;
        if (v.g1 && v.w1) model_mem[v.a1] = v.d1;
        if (mem_write_enable) tbmem[mem_addr] = mem_write_data;
    endtask

    // Reset pulse in the middle of the cycle following the last applied vector.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check({tag, " p0_rvalid in reset"}, 32'(p0_rvalid), 32'd0);
        check({tag, " p1_rvalid in reset"}, 32'(p1_rvalid), 32'd0);
        check({tag, " p0_rdata in reset"}, p0_rdata, '0);
        check({tag, " p1_rdata in reset"}, p1_rdata, '0);
        sb.delete();
        exp_rd0 = '0;
        exp_rd1 = '0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbmem[i]     = init_val(i);
            model_mem[i] = init_val(i);
        end
        exp_rd0 = '0;
        exp_rd1 = '0;
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("reset p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("reset p0_rdata", p0_rdata, '0);
        check("reset p1_rdata", p1_rdata, '0);
        check("reset gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
        #2;
        reset_n = 1'b1;

        //              r0 w0 l0 a0     d0            r1 w1 l1 a1     d1            g0 g1
        // both read together after reset: port 0 first, then port 1
        vecs.push_back(mk(1, 0, 0, 8'h04, 32'h0,        1, 0, 0, 8'h08, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h08, 32'h0,        0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0));
        // both hold writes: strict alternation
        vecs.push_back(mk(1, 1, 0, 8'h10, 32'h1111_1111, 1, 1, 0, 8'h14, 32'h2222_2222, 1, 0));
        vecs.push_back(mk(1, 1, 0, 8'h10, 32'h3333_3333, 1, 1, 0, 8'h14, 32'h4444_4444, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h10, 32'h5555_5555, 1, 1, 0, 8'h14, 32'h6666_6666, 1, 0));
        vecs.push_back(mk(1, 1, 0, 8'h10, 32'h7777_7777, 1, 1, 0, 8'h14, 32'h8888_8888, 0, 1));
        // p0 reads back its write; p1 then locks for three reads, p0 waits
        vecs.push_back(mk(1, 0, 0, 8'h10, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h20, 32'h0,        1, 0, 1, 8'h14, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h20, 32'h0,        1, 0, 1, 8'h18, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h20, 32'h0,        1, 0, 1, 8'h1C, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h20, 32'h0,        1, 0, 0, 8'h14, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h20, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
        // p0 locks, drops req for a cycle: p1 held off, then wins round-robin
        vecs.push_back(mk(1, 0, 1, 8'h24, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h28, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h24, 32'h0,        1, 0, 0, 8'h28, 32'h0,        0, 1));
        // lock without req is ignored
        vecs.push_back(mk(0, 0, 1, 8'h00, 32'h0,        0, 0, 1, 8'h00, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h04, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h08, 32'h0,        1, 1, 0, 8'h30, 32'hDEAD_BEEF, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h30, 32'h0,        0, 0, 0, 8'h00, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // p0 locked read, reset mid next cycle: response suppressed, lock and
        // last_grant cleared so p0 wins the first cycle after release
        apply(mk(1, 0, 1, 8'h40, 32'h0, 0, 0, 0, 8'h00, 32'h0, 1, 0), "rst0 read");
        pulse_reset("rst0");
        apply(mk(1, 0, 0, 8'h44, 32'h0, 1, 0, 0, 8'h48, 32'h0, 1, 0), "rst0 first");
        apply(mk(0, 0, 0, 8'h00, 32'h0, 1, 0, 0, 8'h48, 32'h0, 0, 1), "rst0 second");
        apply(mk(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0, 0, 0), "rst0 drain");

        // p1 ownership cleared by reset
        apply(mk(0, 0, 0, 8'h00, 32'h0, 1, 0, 1, 8'h50, 32'h0, 0, 1), "rst1 lock");
        pulse_reset("rst1");
        apply(mk(1, 0, 0, 8'h54, 32'h0, 1, 0, 0, 8'h58, 32'h0, 1, 0), "rst1 first");
        apply(mk(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0, 0, 0), "rst1 drain");
        apply(mk(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0, 0, 0), "rst1 idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
